id_exe_skid_stage: RTL and testbench
====================================

ID_EXE_SKID_STAGE -- requirements
Module: id_exe_skid_stage

Interface
REQ-001 The block SHALL have parameter WORD_LEN, default 16, data-word width of IMMG/RD1/RD2.
REQ-002 The block SHALL have parameter INST_LEN, default 16, width of PC and Instruction.
REQ-003 The block SHALL have parameter EXE_CMD_LEN, default 4, width of EXE_CMD.
REQ-004 The block SHALL have parameter CNT_LEN, default 16, width of each performance counter.
REQ-005 The block SHALL have ports, one clock, asynchronous active-high reset:
  clk  in  1  rising-edge clock
  Reset  in  1  asynchronous active-high reset
  flush  in  1  synchronous discard of all held and incoming entries
  cnt_clr  in  1  synchronous clear of both counters
  in_valid  in  1  ID stage presents a bundle
  in_ready  out  1  stage can accept a bundle this cycle
  ImSel_IN, xSel_IN, Reg_W_En_IN, BranchTK_IN  in  1 each  control bits
  EXE_CMD_IN  in  EXE_CMD_LEN  ALU command
  PC_IN, Instruction_IN  in  INST_LEN each  PC and instruction
  IMMG_IN, RD1_IN, RD2_IN  in  WORD_LEN each  immediate, operands
  out_valid  out  1  EXE stage bundle is valid
  out_ready  in  1  EXE stage consumes the bundle this cycle
  ImSel, xSel, Reg_W_En, BranchTK, EXE_CMD, PC, Instruction, IMMG, RD1, RD2  out  as inputs  registered bundle
  stall_cnt  out  CNT_LEN  back-pressure cycle count
  flush_cnt  out  CNT_LEN  discarded-bundle count

Function
REQ-006 Accept SHALL occur when in_valid && in_ready; release SHALL occur when out_valid && out_ready.
REQ-007 Storage SHALL be a main register plus one skid register; state SHALL be EMPTY, FULL or SKID.
REQ-008 in_ready SHALL be 1 in EMPTY and FULL, 0 in SKID, decoded from state registers only (no combinational path from out_ready or in_valid).
REQ-009 out_valid SHALL be 1 in FULL and SKID; the output bundle SHALL always be the main register.
REQ-010 EMPTY: accept -> FULL, main <= inputs; else stay EMPTY.
REQ-011 FULL: accept and release -> FULL, main <= inputs; accept only -> SKID, skid <= inputs; release only -> EMPTY; neither -> hold.
REQ-012 SKID: release -> FULL, main <= skid; no release -> hold both registers.
REQ-013 Latency SHALL be exactly 1 cycle from accept in EMPTY (or in FULL with simultaneous release) to out_valid with that bundle.
REQ-014 Bundles SHALL leave in acceptance order; none SHALL be dropped or duplicated except by flush.
REQ-015 While out_valid = 0, ImSel, xSel, Reg_W_En, BranchTK and EXE_CMD outputs SHALL be 0 (bubble); PC, Instruction, IMMG, RD1, RD2 SHALL hold their last value.
REQ-016 flush SHALL take priority over every other event: next state EMPTY, any same-cycle accept discarded, held bundles discarded, in_ready = 1 next cycle.
REQ-017 in_ready SHALL not be gated by flush; an input presented during flush counts as accepted and discarded.
REQ-018 stall_cnt SHALL increment by 1 each cycle with out_valid && !out_ready && !flush, saturating at 2^CNT_LEN-1.
REQ-019 flush_cnt SHALL increment on a flush cycle by the number of bundles discarded (0, 1, 2 or 3: held entries plus a same-cycle accept), saturating at 2^CNT_LEN-1.
REQ-020 cnt_clr SHALL zero both counters next cycle and take priority over same-cycle increments.

Reset
REQ-021 Reset = 1 SHALL immediately, without waiting for clk, force state EMPTY, all bundle outputs, skid register and both counters to 0, out_valid = 0, in_ready = 1.
REQ-022 Reset asserted mid-transfer SHALL discard all held bundles without counting them in flush_cnt.
REQ-023 First accept SHALL be possible on the first rising clk edge after Reset deasserts.

Verification
REQ-024 Pass-through: out_ready = 1, in_valid = 1 for 4 cycles with PC_IN 0x0010..0x0013 -> PC 0x0010..0x0013 on consecutive cycles, 1-cycle latency, stall_cnt = 0.
REQ-025 Skid fill: PC_IN 0x0100, 0x0101 accepted with out_ready = 0 -> in_ready = 0 after second accept, PC = 0x0100 held; out_ready = 1 two cycles -> 0x0100 then 0x0101, in_ready back to 1; stall_cnt = 2.
REQ-026 Flush in SKID with in_valid = 1 -> next cycle out_valid = 0, Reg_W_En = BranchTK = EXE_CMD = 0, in_ready = 1, flush_cnt = 3.
REQ-027 Saturation: CNT_LEN = 4, out_ready = 0 for 20 cycles with out_valid = 1 -> stall_cnt = 15; cnt_clr with stall -> 0 next cycle.
REQ-028 Async reset asserted between edges while in SKID -> outputs 0, out_valid = 0, in_ready = 1 before next clk edge; flush_cnt stays 0.

Source files
------------

// File: rtl/id_exe_skid_stage_if.sv
// ID->EXE handshake bundle: the ID-side inputs, the registered EXE-side outputs and
// the valid/ready pair for each side.
interface id_exe_skid_stage_if #(
    parameter int WORD_LEN    = 16,
    parameter int INST_LEN    = 16,
    parameter int EXE_CMD_LEN = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   ImSel_IN;
    logic                   xSel_IN;
    logic                   Reg_W_En_IN;
    logic                   BranchTK_IN;
    logic [EXE_CMD_LEN-1:0] EXE_CMD_IN;
    logic [INST_LEN-1:0]    PC_IN;
    logic [INST_LEN-1:0]    Instruction_IN;
    logic [WORD_LEN-1:0]    IMMG_IN;
    logic [WORD_LEN-1:0]    RD1_IN;
    logic [WORD_LEN-1:0]    RD2_IN;

    logic                   out_valid;
    logic                   out_ready;
    logic                   ImSel;
    logic                   xSel;
    logic                   Reg_W_En;
    logic                   BranchTK;
    logic [EXE_CMD_LEN-1:0] EXE_CMD;
    logic [INST_LEN-1:0]    PC;
    logic [INST_LEN-1:0]    Instruction;
    logic [WORD_LEN-1:0]    IMMG;
    logic [WORD_LEN-1:0]    RD1;
    logic [WORD_LEN-1:0]    RD2;

    // Pipeline stage view.
    modport slave (
        input  in_valid, ImSel_IN, xSel_IN, Reg_W_En_IN, BranchTK_IN, EXE_CMD_IN,
               PC_IN, Instruction_IN, IMMG_IN, RD1_IN, RD2_IN, out_ready,
        output in_ready, out_valid, ImSel, xSel, Reg_W_En, BranchTK, EXE_CMD,
               PC, Instruction, IMMG, RD1, RD2
    );

    // Surrounding pipeline (ID producer and EXE consumer) view.
    modport master (
        output in_valid, ImSel_IN, xSel_IN, Reg_W_En_IN, BranchTK_IN, EXE_CMD_IN,
               PC_IN, Instruction_IN, IMMG_IN, RD1_IN, RD2_IN, out_ready,
        input  in_ready, out_valid, ImSel, xSel, Reg_W_En, BranchTK, EXE_CMD,
               PC, Instruction, IMMG, RD1, RD2
    );
endinterface

// File: rtl/id_exe_skid_stage.sv
// ID/EXE pipeline register with a one-entry skid buffer, so in_ready is a pure
// register decode. Also counts back-pressure cycles and flushed bundles.
module id_exe_skid_stage #(
    parameter int WORD_LEN    = 16,
    parameter int INST_LEN    = 16,
    parameter int EXE_CMD_LEN = 4,
    parameter int CNT_LEN     = 16
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                flush,
    input  logic                cnt_clr,
    id_exe_skid_stage_if.slave  bus,
    output logic [CNT_LEN-1:0]  stall_cnt,
    output logic [CNT_LEN-1:0]  flush_cnt
);
    localparam int DATA_W = 2 * INST_LEN + 3 * WORD_LEN;
    localparam int BUN_W  = 4 + EXE_CMD_LEN + DATA_W;
    localparam logic [CNT_LEN-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BUN_W-1:0]   main_q, main_d;
    logic [BUN_W-1:0]   skid_q, skid_d;
    logic [BUN_W-1:0]   in_bundle;
    logic [CNT_LEN-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_LEN-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_LEN:0]   flush_sum;
    logic [1:0]         held;
    logic [1:0]         discard;
    logic               out_valid_w;
    logic               accept;
    logic               rel;

    assign in_bundle = {bus.ImSel_IN, bus.xSel_IN, bus.Reg_W_En_IN, bus.BranchTK_IN,
                        bus.EXE_CMD_IN, bus.PC_IN, bus.Instruction_IN,
                        bus.IMMG_IN, bus.RD1_IN, bus.RD2_IN};

    assign out_valid_w  = (state_q != EMPTY);
    assign bus.in_ready = (state_q != SKID);
    assign bus.out_valid = out_valid_w;
    assign accept = bus.in_valid && (state_q != SKID);
    assign rel    = out_valid_w && bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = FULL;
                        main_d  = in_bundle;
                    end
                end
                FULL: begin
                    if (accept && rel) begin
                        main_d = in_bundle;
                    end else if (accept) begin
                        state_d = SKID;
                        skid_d  = in_bundle;
                    end else if (rel) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (rel) begin
                        state_d = FULL;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // A flush discards every held entry plus whatever is presented that cycle,
    // even in SKID where in_ready is low.
    always_comb begin
        held        = (state_q == SKID) ? 2'd2 : ((state_q == FULL) ? 2'd1 : 2'd0);
        discard     = held + {1'b0, bus.in_valid};
        flush_sum   = {1'b0, flush_cnt_q} + {{(CNT_LEN - 1){1'b0}}, discard};
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (out_valid_w && !bus.out_ready && !flush && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush) begin
                flush_cnt_d = flush_sum[CNT_LEN] ? CNT_MAX : flush_sum[CNT_LEN-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Control fields read as a bubble whenever nothing valid is presented.
    assign bus.ImSel    = out_valid_w & main_q[BUN_W-1];
    assign bus.xSel     = out_valid_w & main_q[BUN_W-2];
    assign bus.Reg_W_En = out_valid_w & main_q[BUN_W-3];
    assign bus.BranchTK = out_valid_w & main_q[BUN_W-4];
    assign bus.EXE_CMD  = out_valid_w ? main_q[DATA_W +: EXE_CMD_LEN] : '0;
    assign {bus.PC, bus.Instruction, bus.IMMG, bus.RD1, bus.RD2} = main_q[DATA_W-1:0];

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_id_exe_skid_stage.sv
// Directed bench for id_exe_skid_stage: a scoreboard queue of expected PCs is popped
// by a monitor on every release; directed checks cover handshake, counters and reset.
module tb_id_exe_skid_stage;
    localparam int CNT_LEN = 4;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    logic flush = 1'b0;
    logic cnt_clr = 1'b0;
    logic [CNT_LEN-1:0] stall_cnt;
    logic [CNT_LEN-1:0] flush_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    id_exe_skid_stage_if #(.WORD_LEN(16), .INST_LEN(16), .EXE_CMD_LEN(4)) bus();

    id_exe_skid_stage #(
        .WORD_LEN(16), .INST_LEN(16), .EXE_CMD_LEN(4), .CNT_LEN(CNT_LEN)
    ) dut (
        .clk(clk), .Reset(Reset), .flush(flush), .cnt_clr(cnt_clr),
        .bus(bus), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Expected bundle derived from a PC: {ImSel,xSel,Reg_W_En,BranchTK,EXE_CMD,PC,Instr,IMMG,RD1,RD2}.
    function automatic logic [87:0] mk(input logic [15:0] pc);
        mk = {pc[0], pc[1], 1'b1, pc[2], pc[3:0] | 4'h1, pc, pc ^ 16'hA5A5,
              pc + 16'h1000, ~pc, {pc[7:0], pc[15:8]}};
    endfunction

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] pc);
        {bus.ImSel_IN, bus.xSel_IN, bus.Reg_W_En_IN, bus.BranchTK_IN, bus.EXE_CMD_IN,
         bus.PC_IN, bus.Instruction_IN, bus.IMMG_IN, bus.RD1_IN, bus.RD2_IN} = mk(pc);
        bus.in_valid = 1'b1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // Monitor: every release is compared against the oldest expected bundle.
    always @(negedge clk) begin
        logic [15:0] pc;
        if (!Reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", {72'd0, bus.PC}, 88'd0);
            end else begin
                pc = exp_q.pop_front();
                check("sb_bundle", {bus.ImSel, bus.xSel, bus.Reg_W_En, bus.BranchTK, bus.EXE_CMD,
                                    bus.PC, bus.Instruction, bus.IMMG, bus.RD1, bus.RD2}, mk(pc));
                $display("txn release PC=%04h expected=%04h", bus.PC, pc);
            end
        end
    end

    initial begin
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        drive(16'h0);
        bus.in_valid = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_pc", bus.PC, 0);
        check("rst_ctrl", {bus.ImSel, bus.Reg_W_En, bus.EXE_CMD}, 0);
        check("rst_cnts", {stall_cnt, flush_cnt}, 0);
        step();
        Reset = 1'b0;

        // Pass-through with 1-cycle latency
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            drive(16'h0010 + 16'(i));
            exp_q.push_back(16'h0010 + 16'(i));
            @(negedge clk);
            check("pt_valid", bus.out_valid, (i > 0) ? 1 : 0);
            if (i > 0) check("pt_pc", bus.PC, 16'h0010 + 16'(i - 1));
        end
        step();
        idle();
        @(negedge clk);
        check("pt_last_pc", bus.PC, 16'h0013);
        step();
        @(negedge clk);
        check("pt_empty", bus.out_valid, 0);
        check("pt_stall", stall_cnt, 0);

        // Skid fill and drain
        step();
        cnt_clr = 1'b1;
        bus.out_ready = 1'b0;
        step();
        cnt_clr = 1'b0;
        drive(16'h0100);
        exp_q.push_back(16'h0100);
        step();
        drive(16'h0101);
        exp_q.push_back(16'h0101);
        step();
        idle();
        @(negedge clk);
        check("skid_in_ready", bus.in_ready, 0);
        check("skid_hold_pc", bus.PC, 16'h0100);
        step();
        bus.out_ready = 1'b1;
        step();
        @(negedge clk);
        check("skid_ready_back", bus.in_ready, 1);
        step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("skid_drained", bus.out_valid, 0);
        check("skid_stall_cnt", stall_cnt, 2);
        check("bubble_ctrl", {bus.ImSel, bus.xSel, bus.Reg_W_En, bus.BranchTK, bus.EXE_CMD}, 0);
        check("bubble_pc_hold", bus.PC, 16'h0101);

        // Flush in SKID with an input presented: 2 held + 1 incoming discarded
        step();
        drive(16'h0200);
        step();
        drive(16'h0201);
        step();
        drive(16'h0202);
        flush = 1'b1;
        @(negedge clk);
        check("flush_pre_in_ready", bus.in_ready, 0);
        step();
        flush = 1'b0;
        idle();
        @(negedge clk);
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_bubble", {bus.Reg_W_En, bus.BranchTK, bus.EXE_CMD}, 0);
        check("flush_in_ready", bus.in_ready, 1);
        check("flush_cnt_3", flush_cnt, 3);

        // Flush in FULL with nothing presented: 1 discarded
        step();
        drive(16'h0300);
        step();
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("flush_cnt_4", flush_cnt, 4);
        check("flush_full_valid", bus.out_valid, 0);

        // Stall counter saturation and clear
        step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        drive(16'h0400);
        exp_q.push_back(16'h0400);
        step();
        idle();
        repeat (20) step();
        @(negedge clk);
        check("stall_sat", stall_cnt, 15);
        step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        drive(16'h0401);
        exp_q.push_back(16'h0401);
        @(negedge clk);
        check("clr_stall", stall_cnt, 0);
        check("clr_flush", flush_cnt, 0);

        // Asynchronous reset while in SKID
        step();
        idle();
        @(negedge clk);
        check("pre_rst_skid", bus.in_ready, 0);
        #2;
        Reset = 1'b1;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_outputs", {bus.ImSel, bus.Reg_W_En, bus.EXE_CMD, bus.PC, bus.RD1}, 0);
        check("arst_flush_cnt", flush_cnt, 0);
        check("arst_stall_cnt", stall_cnt, 0);
        exp_q.delete();

        // First accept on the first edge after reset release
        step();
        Reset = 1'b0;
        drive(16'h0500);
        exp_q.push_back(16'h0500);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_empty", bus.out_valid, 0);
        step();
        idle();
        @(negedge clk);
        check("post_rst_valid", bus.out_valid, 1);
        check("post_rst_pc", bus.PC, 16'h0500);
        step();
        @(negedge clk);
        check("post_rst_drained", bus.out_valid, 0);
        check("post_rst_flush_cnt", flush_cnt, 0);
        check("sb_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
